uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART serial transmitter and successor to the fixed 8N1 transmitter. It serialises one parallel word per valid/ready handshake, LSB first, with a start bit, optional parity and 1 or 2 stop bits. An internal baud divider sets the bit period, so the block runs from the system clock directly. It sits between the on-chip data source and the board TX pin.

Parameters:
CLK_DIV, 16, system clocks per serial bit; legal range ≥ 2.
DATA_BITS, 8, data bits per frame; legal range 5 to 9.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
tx_data  input  DATA_BITS  word to send; sampled only on handshake.
tx_valid  input  1  source has a word on tx_data.
tx_ready  output  1  block can accept a word this cycle.
txd  output  1  serial line; idle high; registered.
tx_busy  output  1  frame in progress (any state other than IDLE).
tx_done  output  1  one-cycle pulse on completion of the final stop bit.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, txd = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, baud counter = 0, bit counter = 0, shift register = 0. Reset mid-frame aborts the frame at once and txd returns high with no glitch low.
- Handshake: a word is accepted on a rising edge where tx_valid = 1 and tx_ready = 1.
  - tx_ready = 1 only in IDLE, so it is a registered-state decode and does not depend on tx_valid combinationally.
  - tx_data is copied into the shift register at acceptance. Later changes to tx_data do not affect the frame.
- States:
  - IDLE: txd = 1. On acceptance, go to START.
  - START: txd = 0 for CLK_DIV cycles. Then go to DATA.
  - DATA: txd = shift register LSB. The shift register moves right by one each bit period. After DATA_BITS bit periods, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
  - PARITY: txd = XOR-reduction of the accepted word, inverted when PARITY_ODD = 1. Lasts one bit period, then go to STOP.
  - STOP: txd = 1 for STOP_BITS × CLK_DIV cycles. Then go to IDLE.
- Timing: txd changes only on state or bit boundaries and is driven from a register.
  - Latency: txd goes low on the clock edge after the accepting edge.
  - Each bit lasts exactly CLK_DIV cycles.
  - Total frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLK_DIV cycles.
- Baud counter: counts 0 to CLK_DIV−1, width $clog2(CLK_DIV). It wraps to 0 at each bit boundary and is held at 0 in IDLE.
- Bit counter: width $clog2(DATA_BITS+1). It is cleared on entry to DATA and on entry to STOP.
- tx_done: high for exactly one cycle, aligned with the STOP→IDLE transition cycle. It is never asserted for a frame aborted by reset.
- Back-to-back frames: with tx_valid held high, the next word is accepted in the single IDLE cycle. The inter-frame gap is therefore exactly 1 clock of txd = 1 beyond the stop bits.
- tx_valid asserted while busy: ignored. No capture occurs and the frame is not corrupted.
- Parameter checks: an elaboration-time check fails the build if CLK_DIV < 2, DATA_BITS is outside 5 to 9, or STOP_BITS is not 1 or 2.

Test Plan:
- Basic frame. Config: CLK_DIV=4, 8N1. Stimulus: send 0xA5. Required response: txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_busy high for 40 cycles. tx_done pulses once at the frame end. tx_ready is low throughout the frame.
- Parity. Config: CLK_DIV=4, 8 data bits, PARITY_EN=1. Stimulus: send 0x07 with even parity, then send 0x03 with odd parity. Required response: parity bit = 1 in both cases. Frame length = 44 cycles.
- Two stop bits, short word. Config: DATA_BITS=5, STOP_BITS=2, CLK_DIV=4. Stimulus: send 5'h1F. Required response: 0,1,1,1,1,1,1,1. The stop level lasts 8 cycles. Frame length = 32 cycles.
- Back-to-back. Stimulus: tx_valid held high, sending 0x55 then 0xAA with 8N1 and CLK_DIV=4. Required response: exactly 1 idle-high cycle between the frames. Both words are serialised correctly. Two tx_done pulses.
- Reset mid-frame. Stimulus: rst = 0 for 1 cycle during the DATA bit 3 period. Required response: txd = 1 and tx_busy = 0 immediately (asynchronous). No tx_done pulse. The next accepted word produces a clean full frame.
- Input stability. Stimulus: toggle tx_data and pulse tx_valid during a frame. Required response: the transmitted bits match the originally accepted word, and no extra frame is started.

Source files
------------

// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param_if
// Description : Valid/ready word handshake between a data source and the
//               parametrised UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter: start bit, LSB-first data,
//               optional parity, 1 or 2 stop bits, internal baud divider.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    uart_tx_param_if.slave      s_if,
    output      logic           txd,
    output      logic           tx_busy,
    output      logic           tx_done
);

    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("uart_tx_param: CLK_DIV must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  c_DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  c_STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              c_PAR_ODD   = (PARITY_ODD != 0);
    localparam logic              c_PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  baud_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        baud_last = (baud_q == c_BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (s_if.tx_valid) begin
                    state_d = S_START;
                    shift_d = s_if.tx_data;
                    // Parity is taken from the whole word now, since the shifter is consumed.
                    par_d   = (^s_if.tx_data) ^ c_PAR_ODD;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == c_DATA_LAST) begin
                        state_d = c_PAR_EN ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (bit_q == c_STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The line level follows the current state one clock later, from a flop.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
            S_PARITY: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    assign txd         = txd_q;
    assign tx_busy     = (state_q != S_IDLE);
    assign s_if.tx_ready = (state_q == S_IDLE);
    assign tx_done     = (state_q == S_STOP) && baud_last && (bit_q == c_STOP_LAST);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Directed self-checking bench for four uart_tx_param configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [3:0] valid;
    logic [8:0] data [4];
    logic [3:0] txd_w, busy_w, done_w, ready_w;

    int vectors = 0;
    int errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2; all at CLK_DIV = 4
    uart_tx_param_if #(.DATA_BITS(8)) if_a ();
    uart_tx_param_if #(.DATA_BITS(8)) if_p ();
    uart_tx_param_if #(.DATA_BITS(8)) if_o ();
    uart_tx_param_if #(.DATA_BITS(5)) if_s ();

    assign if_a.tx_valid = valid[0];
    assign if_p.tx_valid = valid[1];
    assign if_o.tx_valid = valid[2];
    assign if_s.tx_valid = valid[3];
    assign if_a.tx_data  = data[0][7:0];
    assign if_p.tx_data  = data[1][7:0];
    assign if_o.tx_data  = data[2][7:0];
    assign if_s.tx_data  = data[3][4:0];
    assign ready_w = {if_s.tx_ready, if_o.tx_ready, if_p.tx_ready, if_a.tx_ready};

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk(clk), .rst(rst_a), .s_if(if_a.slave), .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_p (.clk(clk), .rst(rst_b), .s_if(if_p.slave), .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_o (.clk(clk), .rst(rst_b), .s_if(if_o.slave), .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_s (.clk(clk), .rst(rst_b), .s_if(if_s.slave), .txd(txd_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; word is accepted on the next posedge. exp_bits holds
    // the line levels bit by bit (bit 0 = start bit), each lasting 4 clocks.
    task automatic run_frame(input int sel, input logic [8:0] word, input int nbits,
                             input logic [15:0] exp_bits, input bit hold,
                             input logic [8:0] next_word, input bit disturb,
                             input string tag);
        int n;
        n = nbits * 4;
        data[sel]  = word;
        valid[sel] = 1'b1;
        @(negedge clk);
        if (hold) data[sel] = next_word;
        else      valid[sel] = 1'b0;
        chk($sformatf("%s acc busy", tag), {15'd0, busy_w[sel]}, 16'd1);
        chk($sformatf("%s acc ready", tag), {15'd0, ready_w[sel]}, 16'd0);
        chk($sformatf("%s acc txd", tag), {15'd0, txd_w[sel]}, 16'd1);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (disturb) begin
                if (c % 7 == 3) begin
                    valid[sel] = 1'b1;
                    data[sel]  = ~word;
                end else begin
                    valid[sel] = 1'b0;
                end
            end
            chk($sformatf("%s c%0d txd", tag, c), {15'd0, txd_w[sel]}, {15'd0, exp_bits[(c-1)/4]});
            chk($sformatf("%s c%0d busy", tag, c), {15'd0, busy_w[sel]}, {15'd0, (c < n)});
            chk($sformatf("%s c%0d done", tag, c), {15'd0, done_w[sel]}, {15'd0, (c == n - 1)});
            chk($sformatf("%s c%0d ready", tag, c), {15'd0, ready_w[sel]}, {15'd0, (c >= n)});
        end
        if (!hold) valid[sel] = 1'b0;
    endtask

    initial begin
        valid = 4'b0000;
        for (int i = 0; i < 4; i++) data[i] = 9'h000;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state on every instance
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst txd%0d", i), {15'd0, txd_w[i]}, 16'd1);
            chk($sformatf("rst ready%0d", i), {15'd0, ready_w[i]}, 16'd1);
            chk($sformatf("rst busy%0d", i), {15'd0, busy_w[i]}, 16'd0);
            chk($sformatf("rst done%0d", i), {15'd0, done_w[i]}, 16'd0);
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle txd", {15'd0, txd_w[0]}, 16'd1);

        // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
        run_frame(0, 9'h0A5, 10, 16'b0000_0011_0100_1010, 1'b0, 9'h000, 1'b0, "a5");
        repeat (2) @(negedge clk);

        // 0x07 even parity -> 1: 0,1,1,1,0,0,0,0,0,1,1
        run_frame(1, 9'h007, 11, 16'b0000_0110_0000_1110, 1'b0, 9'h000, 1'b0, "p07");
        repeat (2) @(negedge clk);

        // 0x03 odd parity -> 1: 0,1,1,0,0,0,0,0,0,1,1
        run_frame(2, 9'h003, 11, 16'b0000_0110_0000_0110, 1'b0, 9'h000, 1'b0, "o03");
        repeat (2) @(negedge clk);

        // 5'h1F, two stop bits: 0,1,1,1,1,1,1,1
        run_frame(3, 9'h01F, 8, 16'b0000_0000_1111_1110, 1'b0, 9'h000, 1'b0, "s1f");
        repeat (2) @(negedge clk);

        // Back-to-back 0x55 then 0xAA with tx_valid held high
        run_frame(0, 9'h055, 10, 16'b0000_0010_1010_1010, 1'b1, 9'h0AA, 1'b0, "b2b55");
        chk("b2b gap ready", {15'd0, ready_w[0]}, 16'd1);
        chk("b2b gap txd", {15'd0, txd_w[0]}, 16'd1);
        run_frame(0, 9'h0AA, 10, 16'b0000_0011_0101_0100, 1'b0, 9'h000, 1'b0, "b2baa");
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0x5A
        data[0]  = 9'h05A;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre-rst busy", {15'd0, busy_w[0]}, 16'd1);
        chk("pre-rst txd bit3", {15'd0, txd_w[0]}, 16'd1);
        #2 rst_a = 1'b0;
        #1;
        chk("abort txd", {15'd0, txd_w[0]}, 16'd1);
        chk("abort busy", {15'd0, busy_w[0]}, 16'd0);
        chk("abort done", {15'd0, done_w[0]}, 16'd0);
        chk("abort ready", {15'd0, ready_w[0]}, 16'd1);
        @(negedge clk);
        rst_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d done", c), {15'd0, done_w[0]}, 16'd0);
            chk($sformatf("post-rst c%0d txd", c), {15'd0, txd_w[0]}, 16'd1);
            chk($sformatf("post-rst c%0d busy", c), {15'd0, busy_w[0]}, 16'd0);
        end
        // 0x3C: 0,0,0,1,1,1,1,0,0,1
        run_frame(0, 9'h03C, 10, 16'b0000_0010_0111_1000, 1'b0, 9'h000, 1'b0, "clean3c");
        repeat (2) @(negedge clk);

        // tx_data/tx_valid disturbed mid-frame while sending 0xC3: 0,1,1,0,0,0,0,1,1,1
        run_frame(0, 9'h0C3, 10, 16'b0000_0011_1000_0110, 1'b0, 9'h000, 1'b1, "stab");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("stab after c%0d busy", c), {15'd0, busy_w[0]}, 16'd0);
            chk($sformatf("stab after c%0d txd", c), {15'd0, txd_w[0]}, 16'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
